// File: rtl/delay_line_var.sv
// Programmable-depth delay line (1..DEPTH cycles) with clock enable and settle tracking.
// Optional drop statistics enabled by defining DELAY_LINE_VAR_STAT_EN.
module delay_line_var #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_settling,
    output logic             o_sel_changed
`ifdef DELAY_LINE_VAR_STAT_EN
    ,
    output logic [15:0]      o_drop_cnt
`endif
);

    typedef enum logic {RUN, SETTLE} state_t;

    localparam int CNT_W = SEL_W + 1;
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(DEPTH - 1);

    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
        if ({1'b0, s} >= CNT_W'(DEPTH)) return MAX_SEL;
        return s;
    endfunction

    // DEPTH-1 chain registers plus the output register give DEPTH cycles at max sel.
    logic [WIDTH-1:0] dat_q [DEPTH-1];
    logic [DEPTH-2:0] vld_q;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, sel_c;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             changed;

    logic [WIDTH-1:0] out_data_q;
    logic             out_vld_q, out_settling_q, out_chg_q;

    logic [WIDTH-1:0] tap_data;
    logic             tap_vld;

    assign sel_c   = clamp_sel(sel);
    assign changed = (sel_c != sel_q);

    always_comb begin
        sel_d   = sel_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (changed) begin
            sel_d   = sel_c;
            state_d = SETTLE;
            cnt_d   = CNT_W'(sel_c) + CNT_W'(1);
        end else if (state_q == SETTLE) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Tap 0 is the live input; tap k is chain register k-1. The selected delay is
    // the one being committed this cycle, so the output never mixes old and new taps.
    always_comb begin
        tap_data = i_data;
        tap_vld  = i_valid;
        for (int k = 1; k < DEPTH; k++) begin
            if (sel_d == SEL_W'(k)) begin
                tap_data = dat_q[k-1];
                tap_vld  = vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            sel_q          <= sel_c;
            cnt_q          <= '0;
            out_data_q     <= '0;
            out_vld_q      <= 1'b0;
            out_settling_q <= 1'b0;
            out_chg_q      <= 1'b0;
            vld_q          <= '0;
            for (int k = 0; k < DEPTH - 1; k++) dat_q[k] <= '0;
        end else begin
            out_chg_q <= 1'b0;
            if (ce) begin
                dat_q[0] <= i_data;
                vld_q[0] <= i_valid;
                for (int k = 1; k < DEPTH - 1; k++) begin
                    dat_q[k] <= dat_q[k-1];
                    vld_q[k] <= vld_q[k-1];
                end
                state_q        <= state_d;
                sel_q          <= sel_d;
                cnt_q          <= cnt_d;
                out_data_q     <= tap_data;
                out_vld_q      <= tap_vld & (state_d == RUN);
                out_settling_q <= (state_d == SETTLE);
                out_chg_q      <= changed;
            end
        end
    end

    assign o_data        = out_data_q;
    assign o_valid       = out_vld_q;
    assign o_settling    = out_settling_q;
    assign o_sel_changed = out_chg_q;

`ifdef DELAY_LINE_VAR_STAT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] drop_q;

    // A drop is a valid word at the committed tap that settling suppresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (ce && (state_d == SETTLE) && tap_vld) begin
            drop_q <= sat_inc16(drop_q);
        end
    end

    assign o_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_delay_line_var.sv
// Scoreboarded random/directed bench for delay_line_var (DEPTH=6 to exercise clamping).
// Checks o_drop_cnt too when DELAY_LINE_VAR_STAT_EN is defined.
module tb_delay_line_var;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 6;
    localparam int SEL_W   = 3;
    localparam int AGE_MAX = 1000;

    logic             clk = 1'b0;
    logic             reset;
    logic             ce;
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_settling;
    logic             o_sel_changed;
`ifdef DELAY_LINE_VAR_STAT_EN
    logic [15:0]      o_drop_cnt;
`endif

    always #5 clk = ~clk;

    delay_line_var #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .ce            (ce),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .sel           (sel),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_settling    (o_settling),
        .o_sel_changed (o_sel_changed)
`ifdef DELAY_LINE_VAR_STAT_EN
        ,
        .o_drop_cnt    (o_drop_cnt)
`endif
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             valid;
        logic             settling;
        logic             chg;
        logic [15:0]      drop;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model: history of accepted words, and the window of enabled
    // cycles since the last accepted select change.
    logic [WIDTH:0] hist[$];
    int   m_sel = 0;
    int   age   = AGE_MAX;
    int   chg_s = 0;
    int   drop  = 0;
    exp_t cur   = '{default: '0};

    function automatic int clampi(input int s);
        return (s >= DEPTH) ? DEPTH - 1 : s;
    endfunction

    task automatic step(input logic r, input logic c, input int s,
                        input logic v, input logic [WIDTH-1:0] d);
        int             cs;
        logic           chg;
        logic           settl;
        logic [WIDTH:0] w;
        @(negedge clk);
        reset   = r;
        ce      = c;
        sel     = SEL_W'(s);
        i_valid = v;
        i_data  = d;
        cs = clampi(s);
        if (r) begin
            hist.delete();
            m_sel = cs;
            age   = AGE_MAX;
            chg_s = 0;
            drop  = 0;
            cur   = '{default: '0};
        end else if (c) begin
            hist.push_front({v, d});
            if (hist.size() > 16) void'(hist.pop_back());
            chg = (cs != m_sel);
            if (chg) begin
                m_sel = cs;
                age   = 0;
                chg_s = cs;
            end else if (age < AGE_MAX) begin
                age++;
            end
            settl = (age <= chg_s);
            w = (m_sel < hist.size()) ? hist[m_sel] : '0;
            cur.data     = w[WIDTH-1:0];
            cur.valid    = w[WIDTH] && !settl;
            cur.settling = settl;
            cur.chg      = chg;
            if (settl && w[WIDTH] && drop < 65535) drop++;
            cur.drop     = 16'(drop);
        end else begin
            cur.chg = 1'b0;
        end
        sb.push_back(cur);
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (o_data !== e.data) begin
                    miscompares++;
                    $display("FAIL o_data t=%0t got %h want %h", $time, o_data, e.data);
                end
                if (o_valid !== e.valid) begin
                    miscompares++;
                    $display("FAIL o_valid t=%0t got %b want %b", $time, o_valid, e.valid);
                end
                if (o_settling !== e.settling) begin
                    miscompares++;
                    $display("FAIL o_settling t=%0t got %b want %b", $time, o_settling, e.settling);
                end
                if (o_sel_changed !== e.chg) begin
                    miscompares++;
                    $display("FAIL o_sel_changed t=%0t got %b want %b", $time, o_sel_changed, e.chg);
                end
`ifdef DELAY_LINE_VAR_STAT_EN
                if (o_drop_cnt !== e.drop) begin
                    miscompares++;
                    $display("FAIL o_drop_cnt t=%0t got %0d want %0d", $time, o_drop_cnt, e.drop);
                end
`endif
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] ramp;
        int               rs;
        int               budget;
        reset   = 1'b1;
        ce      = 1'b0;
        sel     = '0;
        i_valid = 1'b0;
        i_data  = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 16'($urandom));

        // Fixed delay, sel=3
        ramp = 16'd1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 3, 1'b1, ramp);
            ramp++;
        end

        // Clamp: sel=7 acts as 5; then sel=5 is no change
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 7, 1'b1, ramp);
            ramp++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 5, 1'b1, ramp);
            ramp++;
        end

        // Clock enable toggling with sel=1
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'(i % 2 == 0), 1, 1'b1, ramp);
            ramp++;
        end

        // Sel change 1 -> 4, then 2 while still settling
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1, 1'b1, ramp);
            ramp++;
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 4, 1'b1, ramp);
            ramp++;
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 2, 1'b1, ramp);
            ramp++;
        end

        // Drop statistics: continuous valid stream, sel 0 -> 3
        step(1'b1, 1'b1, 0, 1'b1, ramp);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 0, 1'b1, ramp);
            ramp++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 3, 1'b1, ramp);
            ramp++;
        end
`ifdef DELAY_LINE_VAR_STAT_EN
        @(posedge clk);
        #2;
        vectors++;
        if (o_drop_cnt !== 16'd4) begin
            miscompares++;
            $display("FAIL drop_cnt_directed got %0d want 4", o_drop_cnt);
        end
`endif

        // Randomized traffic
        rs = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rs = int'($urandom_range(0, 7));
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 4) != 0), rs,
                 1'($urandom_range(0, 3) != 0), 16'($urandom));
        end

        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/delay_line_var.md
Name: delay_line_var

Overview:
- Parametrised, synthesizable programmable-depth delay line, the successor to the fixed register chains used in the clocking/delta-delay examples.
- Delays a WIDTH-bit data word and its valid flag by a run-time selectable number of clock cycles (1..DEPTH).
- Has a clock enable and tracks settling after the delay changes, so downstream logic never sees words from a stale tap.
- Sits between a sample source and a consumer that needs programmable alignment.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 8, maximum delay in cycles; legal range 2..256.
- SEL_W, $clog2(DEPTH), width of the delay-select port.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- ce  input  1  clock enable; 0 freezes the chain, settle counter and outputs.
- i_data  input  WIDTH  input word.
- i_valid  input  1  input word qualifier.
- sel  input  SEL_W  delay select; delay = sel+1 cycles; values >= DEPTH are clamped to DEPTH-1.
- o_data  output  WIDTH  delayed word.
- o_valid  output  1  delayed qualifier; forced 0 while settling.
- o_settling  output  1  1 while in SETTLE state.
- o_sel_changed  output  1  one-cycle pulse on each accepted sel change.

Behaviour:
- Reset (reset=1 at rising edge, regardless of ce):
  - all stage data regs <= 0 and all stage valid regs <= 0;
  - o_data=0, o_valid=0, o_settling=0, o_sel_changed=0;
  - sel_q <= clamp(sel); state <= RUN.
- Chain: stage[0] <= {i_valid,i_data}; stage[k] <= stage[k-1]. Updates only when ce=1.
- Output:
  - registered tap. o_data <= stage[sel_q].data when ce=1.
  - o_valid <= stage[sel_q].valid & (state==RUN) when ce=1.
  - Total latency from i_data to o_data is sel_q+1 enabled cycles, and equals exactly DEPTH at maximum sel.
- Each enabled cycle compares clamp(sel) with sel_q. On a mismatch:
  - sel_q <= clamp(sel);
  - o_sel_changed=1 for exactly one cycle;
  - settle counter <= clamp(sel)+1;
  - state <= SETTLE.
- FSM:
  - RUN: normal operation. A sel change goes to SETTLE.
  - SETTLE: o_settling=1 and o_valid=0. Counter decrements on each ce=1 cycle; at 0 go to RUN.
  - A further sel change during SETTLE reloads the counter with the new value and pulses o_sel_changed again. The chain keeps shifting.
- ce=0: o_sel_changed still deasserts after its one cycle. A sel change seen while ce=0 is not evaluated until ce=1.
- Simultaneous reset and sel change: reset wins. sel_q loads the clamped value with no pulse and no SETTLE.
- Reset mid-SETTLE: returns to RUN and clears all valid bits.
- Words enter with i_valid=0 are carried with valid=0. Data is not gated by valid.

Optional Feature:
- Macro: DELAY_LINE_VAR_STAT_EN.
- When defined:
  - adds output o_drop_cnt [15:0];
  - counts words with stage valid=1 at the tap that are suppressed during SETTLE (valid words lost to settling);
  - saturates at 16'hFFFF; cleared by reset.
- When undefined: the port and the counter are absent, and the remaining behaviour is identical.

Test Plan:
- Reset/zero state: reset=1 for 3 cycles with random inputs -> o_data=0, o_valid=0, o_settling=0, o_sel_changed=0.
- Fixed delay: DEPTH=8, sel=3, ce=1, ramp i_data=1,2,3... with i_valid=1 -> value N appears on o_data exactly 4 cycles after it is driven, with o_valid=1.
- Max depth and clamp: DEPTH=6 (SEL_W=3), sel=7 -> treated as 5, latency 6 cycles; sel=5 gives the same output.
- Clock enable: ce toggles 1,0,1,0 with sel=1 -> latency is 2 enabled cycles; outputs hold while ce=0; no word is lost or duplicated.
- Sel change: in RUN with sel=1, switch to sel=4 -> o_sel_changed pulses once, o_settling=1 for 5 enabled cycles, o_valid=0 during that window. Then o_valid=1 with data delayed 5 cycles. Switching again to sel=2 at settle cycle 2 reloads to 3.
- Stats (DELAY_LINE_VAR_STAT_EN): continuous valid stream, sel change 0->3 -> o_drop_cnt=4. With the macro undefined the bench compiles without the port.
